alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Iterative 32-bit multiply/divide unit that sits directly downstream of the ALU operand-select stage. It consumes the selected X/Y operands (`resultX`/`resultY`) alongside the combinational ALU and serves MULT/MULTU/DIV/DIVU. Results go to an internal HI/LO register pair, which is readable by the register-file writeback path and writable by MTHI/MTLO. A start/busy/done handshake lets the controller stall the pipeline while an operation is in flight.

## Interface

- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.

- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request an operation; sampled only when not busy.
- `op`  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `x`  input  32  operand X (multiplicand / dividend), from operand-select `resultX`.
- `y`  input  32  operand Y (multiplier / divisor), from operand-select `resultY`.
- `wrHi`  input  1  MTHI write strobe.
- `wrLo`  input  1  MTLO write strobe.
- `wrData`  input  32  data for `wrHi`/`wrLo`.
- `busy`  output  1  high while the operation is in flight (CALC, FIX).
- `done`  output  1  one-cycle completion pulse.
- `divByZero`  output  1  valid with `done`; high if a DIV/DIVU had `y == 0`.
- `hi`  output  32  HI register.
- `lo`  output  32  LO register.

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE/DONE with `start=1`: latch `op`, `x`, `y`, and `x[31]`/`y[31]` as signs. For signed ops, convert operands to magnitudes. Clear the 6-bit counter, go to CALC.
  - IDLE/DONE with `start=0`: go to IDLE.
- CALC, one iteration per cycle, 32 iterations:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract. Remainder register is 33 bits, and the compare uses 33-bit subtraction.
  - After iteration 31, go to FIX.
- FIX:
  - Signed multiply: negate the 64-bit product if `sx^sy`.
  - Signed divide: negate the quotient if `sx^sy`; give the remainder the sign of `sx`.
  - Write HI = upper/remainder and LO = lower/quotient, then go to DONE.
- Division by zero: skip the sign fixup; LO = 0xFFFF_FFFF, HI = latched original `x`, `divByZero` = 1. Latency is unchanged.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0 (result of two's-complement truncation); no flag.
- `start` in CALC/FIX is ignored; no queueing.
- `wrHi`/`wrLo`:
  - Honoured only in IDLE/DONE; ignored while busy.
  - The write takes effect at the edge.
  - Both strobes asserted together write both registers.
  - A strobe in the same cycle as an accepted `start` is honoured; the later result overwrites it.
- Operands are captured at `start`; later changes on `x`/`y` have no effect.

## Timing

- Reset values: state IDLE; `busy`, `done`, `divByZero` = 0; `hi`, `lo` = 0.
- `rst` mid-operation aborts immediately; no `done` is produced.
- Accepted `start` at edge k gives this sequence:
  - CALC for the cycles after edges k … k+31.
  - FIX after edge k+32.
  - DONE after edge k+33.
- `busy` is high for 33 cycles; `done` is high for exactly one cycle, registered, with `hi`/`lo`/`divByZero` already valid.
- Start-to-done latency is 34 cycles. Back-to-back: a `start` during DONE is accepted, so issue rate is one op per 34 cycles.
- `divByZero` holds until the next accepted `start` or `rst`.
- Outputs are registered; there are no combinational input-to-output paths.

## Configuration

- `ALU_MULDIV_SIGNED_EN` defined:
  - `op` 01/11 perform signed MULT/DIV with magnitude conversion and FIX sign correction.
- `ALU_MULDIV_SIGNED_EN` undefined:
  - `op[0]` is ignored and all ops are unsigned.
  - Sign-handling logic is not compiled.
  - FIX still occupies one cycle, so latency is identical.

## Test plan

- MULTU x=0x1234, y=0x5678 → `done` exactly 34 cycles after the start edge; HI=0x0000_0000, LO=0x0626_0060; `busy` high 33 cycles.
- MULT x=0xFFFF_FFFE, y=3:
  - With macro: HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
  - Without macro: HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIVU 100/7 → LO=14, HI=2. DIV 0xFFFF_FFF9 / 2 (with macro) → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. `divByZero` = 0 in both.
- DIVU 5/0 → LO=0xFFFF_FFFF, HI=5, `divByZero` = 1 with `done`; the next accepted start clears it.
- Handshake and writes:
  - Pulse `start` again and `wrHi` (0xDEAD_BEEF) while busy: both ignored, original result delivered.
  - In IDLE, `wrLo` 0x1234_5678 → LO=0x1234_5678, HI unchanged.
- Assert `rst` 10 cycles into a MULTU → next cycle: `busy` = 0, HI=LO=0, no `done` pulse; a new start then completes normally in 34 cycles.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers and a start/busy/done handshake.
// Define ALU_MULDIV_SIGNED_EN to enable signed MULT/DIV on op[0]; without it every op is unsigned.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             wrHi,
    input  logic             wrLo,
    input  logic [WIDTH-1:0] wrData,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic               div_q;
    logic               zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [5:0]         cnt_q;
`ifdef ALU_MULDIV_SIGNED_EN
    logic               neg_x_q;
    logic               neg_y_q;
`endif

    logic [WIDTH-1:0]   mag_x;
    logic [WIDTH-1:0]   mag_y;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   remd;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        mag_x = x;
        mag_y = y;
`ifdef ALU_MULDIV_SIGNED_EN
        if (op[0] && x[WIDTH-1]) mag_x = -x;
        if (op[0] && y[WIDTH-1]) mag_y = -y;
`endif

        // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Divide: acc low half holds dividend bits shifting out / quotient bits shifting in.
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};

        prod = acc_q;
        quot = acc_q[WIDTH-1:0];
        remd = rem_q;
`ifdef ALU_MULDIV_SIGNED_EN
        if (neg_x_q ^ neg_y_q) begin
            prod = -acc_q;
            quot = -acc_q[WIDTH-1:0];
        end
        if (neg_x_q) remd = -rem_q;
`endif

        if (zero_q) begin
            fix_hi = x_q;
            fix_lo = '1;
        end else if (div_q) begin
            fix_hi = remd;
            fix_lo = quot;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            div_q   <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            x_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef ALU_MULDIV_SIGNED_EN
            neg_x_q <= 1'b0;
            neg_y_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (wrHi) hi_q <= wrData;
                    if (wrLo) lo_q <= wrData;
                    if (start) begin
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        div_q   <= op[1];
                        zero_q  <= op[1] && (y == '0);
                        x_q     <= x;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        b_q     <= op[1] ? mag_y : mag_x;
                        acc_q   <= {{WIDTH{1'b0}}, (op[1] ? mag_x : mag_y)};
`ifdef ALU_MULDIV_SIGNED_EN
                        neg_x_q <= op[0] & x[WIDTH-1];
                        neg_y_q <= op[0] & y[WIDTH-1];
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (div_q) begin
                        rem_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == LAST_ITER) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    dbz_q   <= zero_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign divByZero = dbz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases plus randomized ops against a 64-bit arithmetic model.
// Compile with ALU_MULDIV_SIGNED_EN defined or not; the model follows the same macro.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        wrHi;
    logic        wrLo;
    logic [31:0] wrData;
    logic        busy;
    logic        done;
    logic        divByZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .x         (x),
        .y         (y),
        .wrHi      (wrHi),
        .wrLo      (wrLo),
        .wrData    (wrData),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
        logic            sgn;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned p;
`ifdef ALU_MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        rdz = 1'b0;
        if (o[1]) begin
            if (b == 32'd0) begin
                rl  = 32'hFFFF_FFFF;
                rh  = a;
                rdz = 1'b1;
            end else if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                rl = q[31:0];
                rh = r[31:0];
            end else begin
                rl = a / b;
                rh = a % b;
            end
        end else begin
            if (sgn) p = longint'($signed(a)) * longint'($signed(b));
            else     p = 64'(a) * 64'(b);
            rh = p[63:32];
            rl = p[31:0];
        end
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op, measures latency and busy length, and compares the result with the model.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;
        int          lat;
        int          bcnt;
        bit          got;
        ref_model(o, a, b, eh, el, edz);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        x     = a;
        y     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        x     = $urandom;
        y     = $urandom;
        check_eq("busy_rise", 64'(busy), 64'd1);
        check_eq("done_pulse_end", 64'(done), 64'd0);
        check_eq("dbz_clear", 64'(divByZero), 64'd0);
        lat  = 1;
        bcnt = 0;
        got  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) bcnt++;
                if (inject && lat == 5) begin
                    start  = 1'b1;
                    op     = 2'b10;
                    wrHi   = 1'b1;
                    wrData = 32'hDEAD_BEEF;
                end else begin
                    start = 1'b0;
                    wrHi  = 1'b0;
                end
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!got) begin
            check_eq("done_timeout", 64'(done), 64'd1);
        end else begin
            check_eq("latency", 64'(lat), 64'd34);
            check_eq("busy_cycles", 64'(bcnt), 64'd33);
            check_eq("hi", 64'(hi), 64'(eh));
            check_eq("lo", 64'(lo), 64'(el));
            check_eq("divByZero", 64'(divByZero), 64'(edz));
            check_eq("busy_at_done", 64'(busy), 64'd0);
        end
        exp_hi = eh;
        exp_lo = el;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        x      = '0;
        y      = '0;
        wrHi   = 1'b0;
        wrLo   = 1'b0;
        wrData = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dbz", 64'(divByZero), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 32'h0000_1234, 32'h0000_5678, 1'b0);
        check_eq("multu_lo_const", 64'(lo), 64'h0626_0060);
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(2'b10, 32'd100, 32'd7, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'd5, 32'd0, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // start + wrHi pulsed while busy must both be ignored
        run_op(2'b00, 32'hCAFE_F00D, 32'h0001_0003, 1'b1);

        @(negedge clk);
        wrLo   = 1'b1;
        wrData = 32'h1234_5678;
        @(posedge clk);
        #1;
        wrLo   = 1'b0;
        exp_lo = 32'h1234_5678;
        check_eq("wrlo_lo", 64'(lo), 64'(exp_lo));
        check_eq("wrlo_hi", 64'(hi), 64'(exp_hi));

        @(negedge clk);
        wrHi   = 1'b1;
        wrLo   = 1'b1;
        wrData = $urandom;
        @(posedge clk);
        #1;
        wrHi   = 1'b0;
        wrLo   = 1'b0;
        exp_hi = wrData;
        exp_lo = wrData;
        check_eq("wrboth_hi", 64'(hi), 64'(exp_hi));
        check_eq("wrboth_lo", 64'(lo), 64'(exp_lo));

        // reset 10 cycles into a MULTU
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        x     = 32'h0BAD_F00D;
        y     = 32'h0000_0077;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_hi", 64'(hi), 64'd0);
        check_eq("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check_eq("abort_no_done", 64'(seen), 64'd0);
        run_op(2'b00, 32'h0BAD_F00D, 32'h0000_0077, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), rand_val(), rand_val(), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
